// File: rtl/pwm_pkg.sv
// pwm_pkg: types and defaults shared by the PWM decoder and the PWM generator.
//   CNT_W_DEF   - default width of the measurement counters and outputs
//   pwm_state_t - decoder FSM state encoding
package pwm_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } pwm_state_t;

endpackage

// File: rtl/pwm_decoder_if.sv
// pwm_decoder_if: measurement result bus of the PWM decoder.
//   high_time    - clk cycles high in the last complete period
//   period       - clk cycles between the last two rising edges
//   meas_valid   - one-cycle pulse, high_time/period updated
//   meas_ovf     - qualifies meas_valid, a counter saturated in that period
//   timeout      - one-cycle pulse, no input edge for TIMEOUT_CYC cycles
//   static_level - input level captured at the last timeout
// Modports: master (decoder side), slave (consumer side).
interface pwm_decoder_if #(
  parameter int CNT_W = pwm_pkg::CNT_W_DEF
) ();

  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] period;
  logic             meas_valid;
  logic             meas_ovf;
  logic             timeout;
  logic             static_level;

  modport master (
    output high_time, period, meas_valid, meas_ovf, timeout, static_level
  );

  modport slave (
    input high_time, period, meas_valid, meas_ovf, timeout, static_level
  );

endinterface

// File: rtl/pwm_in_sync.sv
// pwm_in_sync: 2-flop synchronizer plus edge detector for the PWM input.
//   clk, reset - system clock, async active-high reset
//   pwm_in     - asynchronous PWM waveform
//   level      - synchronized level
//   rise, fall - single-cycle edge detects (sync sample vs. delayed copy)
module pwm_in_sync (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sh;
  logic [2:0] primed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh     <= '0;
      primed <= '0;
    end else begin
      sh     <= {sh[1:0], pwm_in};
      primed <= {primed[1:0], 1'b1};
    end
  end

  // Edges are only trusted once every stage holds a real sample; otherwise an
  // input that is already high at reset release would look like a rising edge.
  assign level = sh[1];
  assign rise  = primed[2] &  sh[1] & ~sh[2];
  assign fall  = primed[2] & ~sh[1] &  sh[2];

endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures high time and period of an asynchronous PWM input.
//   clk, reset - system clock, async active-high reset
//   en         - decoder enable (synchronous)
//   pwm_in     - asynchronous PWM waveform
//   meas       - result bus (pwm_decoder_if.master)
// Optional: define PWM_DECODER_TIMEOUT_EN to add the idle-timeout detector;
// without it timeout and static_level stay 0.
//
// state | meaning
// IDLE  | disabled, counters cleared
// SYNC  | waiting for the first rising edge (partial period discarded)
// HIGH  | input high, counting high time
// LOW   | input low, next rising edge completes a measurement
module pwm_decoder import pwm_pkg::*; #(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic pwm_in,
  pwm_decoder_if.master meas
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pwm_state_t       state;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic             sat_flag;
  logic [CNT_W-1:0] high_time_q, period_q;
  logic             meas_valid_q, meas_ovf_q, timeout_q, static_level_q;
  logic             level, rise, fall;

  pwm_in_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

`ifdef PWM_DECODER_TIMEOUT_EN
  localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout_hit;
  assign timeout_hit = !rise && !fall && (idle_cnt == IDLE_LAST);
`else
  logic unused_ok;
  assign unused_ok = ^{level, TIMEOUT_CYC[0]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      period_cnt     <= '0;
      high_cnt       <= '0;
      sat_flag       <= 1'b0;
      high_time_q    <= '0;
      period_q       <= '0;
      meas_valid_q   <= 1'b0;
      meas_ovf_q     <= 1'b0;
      timeout_q      <= 1'b0;
      static_level_q <= 1'b0;
`ifdef PWM_DECODER_TIMEOUT_EN
      idle_cnt       <= '0;
`endif
    end else begin
      meas_valid_q <= 1'b0;
      meas_ovf_q   <= 1'b0;
      timeout_q    <= 1'b0;
      // en low dominates: any edge seen in this cycle is dropped.
      if (!en || state == ST_IDLE) begin
        state      <= en ? ST_SYNC : ST_IDLE;
        period_cnt <= '0;
        high_cnt   <= '0;
        sat_flag   <= 1'b0;
`ifdef PWM_DECODER_TIMEOUT_EN
        idle_cnt   <= '0;
      end else if (timeout_hit) begin
        state          <= ST_SYNC;
        period_cnt     <= '0;
        high_cnt       <= '0;
        sat_flag       <= 1'b0;
        idle_cnt       <= '0;
        timeout_q      <= 1'b1;
        static_level_q <= level;
`endif
      end else begin
`ifdef PWM_DECODER_TIMEOUT_EN
        idle_cnt <= (rise || fall) ? '0 : idle_cnt + IDLE_W'(1);
`endif
        if (rise) begin
          period_cnt <= CNT_ONE;
          high_cnt   <= CNT_ONE;
          sat_flag   <= 1'b0;
        end else begin
          if (period_cnt != CNT_MAX) period_cnt <= period_cnt + CNT_ONE;
          // The fall-detect cycle is already the first low cycle.
          if (state == ST_HIGH && !fall && high_cnt != CNT_MAX)
            high_cnt <= high_cnt + CNT_ONE;
          if (period_cnt == CNT_MAX || high_cnt == CNT_MAX) sat_flag <= 1'b1;
        end
        case (state)
          ST_SYNC: if (rise) state <= ST_HIGH;
          ST_HIGH: if (fall) state <= ST_LOW;
          ST_LOW: begin
            if (rise) begin
              state        <= ST_HIGH;
              high_time_q  <= high_cnt;
              period_q     <= period_cnt;
              meas_valid_q <= 1'b1;
              meas_ovf_q   <= sat_flag || (period_cnt == CNT_MAX) || (high_cnt == CNT_MAX);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign meas.high_time    = high_time_q;
  assign meas.period       = period_q;
  assign meas.meas_valid   = meas_valid_q;
  assign meas.meas_ovf     = meas_ovf_q;
  assign meas.timeout      = timeout_q;
  assign meas.static_level = static_level_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: directed self-checking bench for pwm_decoder.
// Two instances: 16-bit counters (main) and 8-bit counters (saturation).
// Honours PWM_DECODER_TIMEOUT_EN for the stuck-input expectations.
module tb_pwm_decoder;
  import pwm_pkg::*;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic en     = 1'b0;
  logic pwm_in = 1'b0;
  logic en8    = 1'b0;
  logic pwm8   = 1'b0;

  always #5 clk = ~clk;

  pwm_decoder_if #(.CNT_W(16)) m ();
  pwm_decoder_if #(.CNT_W(8))  m8 ();

  pwm_decoder #(.CNT_W(16), .TIMEOUT_CYC(4096)) dut (
    .clk(clk), .reset(reset), .en(en), .pwm_in(pwm_in), .meas(m)
  );

  pwm_decoder #(.CNT_W(8), .TIMEOUT_CYC(4096)) dut8 (
    .clk(clk), .reset(reset), .en(en8), .pwm_in(pwm8), .meas(m8)
  );

  typedef struct {
    int hi;
    int per;
    int ovf;
    int cyc;
  } rep_t;

  int   n_checks  = 0;
  int   n_errors  = 0;
  int   cyc       = 0;
  int   n_timeout = 0;
  rep_t reps[$];
  rep_t reps8[$];
  logic [15:0] prev_hi  = '0, prev_per  = '0;
  logic [7:0]  prev_hi8 = '0, prev_per8 = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_rep(input string tag, input rep_t r, input int hi, input int per, input int ovf);
    check({tag, "_high_time"}, r.hi, hi);
    check({tag, "_period"}, r.per, per);
    check({tag, "_ovf"}, r.ovf, ovf);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pwm(input int h, input int l);
    pwm_in = 1'b1;
    repeat (h) cycle();
    pwm_in = 1'b0;
    repeat (l) cycle();
  endtask

  task automatic run_pwm8(input int h, input int l);
    pwm8 = 1'b1;
    repeat (h) cycle();
    pwm8 = 1'b0;
    repeat (l) cycle();
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Collect reports; high_time/period must not move without meas_valid.
  always @(negedge clk) begin
    if (m.meas_valid)
      reps.push_back('{int'(m.high_time), int'(m.period), int'(m.meas_ovf), cyc});
    else if (!reset) begin
      check("hold_high_time", m.high_time, prev_hi);
      check("hold_period", m.period, prev_per);
    end
    prev_hi  = m.high_time;
    prev_per = m.period;
    if (m8.meas_valid)
      reps8.push_back('{int'(m8.high_time), int'(m8.period), int'(m8.meas_ovf), cyc});
    else if (!reset) begin
      check("hold8_high_time", m8.high_time, prev_hi8);
      check("hold8_period", m8.period, prev_per8);
    end
    prev_hi8  = m8.high_time;
    prev_per8 = m8.period;
    if (m.timeout) n_timeout++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         to_n;
    logic       to_lvl;
    logic [1:0] to_state;
    to_n     = 0;
    to_lvl   = 1'b0;
    to_state = 2'd0;

    // Reset state
    repeat (3) cycle();
    check("rst_high_time", m.high_time, 0);
    check("rst_period", m.period, 0);
    check("rst_meas_valid", m.meas_valid, 0);
    check("rst_meas_ovf", m.meas_ovf, 0);
    check("rst_timeout", m.timeout, 0);
    check("rst_static_level", m.static_level, 0);
    reset = 1'b0;
    en    = 1'b1;
    repeat (5) cycle();

    // Steady 3/10 stream, then duty change to 7/10
    reps.delete();
    repeat (5) run_pwm(3, 7);
    repeat (3) run_pwm(7, 3);
    check("stream_count", reps.size(), 7);
    for (int i = 0; i < reps.size(); i++) begin
      check_rep("stream", reps[i], (i < 5) ? 3 : 7, 10, 0);
      if (i > 0) check("stream_spacing", reps[i].cyc - reps[i-1].cyc, 10);
    end

    // en dropped 2 clk before a rise, then reasserted
    reps.delete();
    en = 1'b0;
    repeat (2) cycle();
    repeat (2) run_pwm(3, 7);
    check("en_off_reports", reps.size(), 0);
    check("en_off_high_time", m.high_time, 7);
    check("en_off_period", m.period, 10);
    en = 1'b1;
    repeat (3) run_pwm(3, 7);
    check("en_on_reports", reps.size(), 2);
    for (int i = 0; i < reps.size(); i++) check_rep("en_on", reps[i], 3, 10, 0);

    // Input stuck high for 5000 clk
    reps.delete();
    pwm_in = 1'b1;
    for (int n = 1; n <= 5000; n++) begin
      cycle();
      if (m.timeout && to_n == 0) begin
        to_n     = n;
        to_lvl   = m.static_level;
        to_state = dut.state;
      end
    end
    check("stuck_reports", reps.size(), 1);
    if (reps.size() > 0) check_rep("stuck_last", reps[0], 3, 10, 0);
`ifdef PWM_DECODER_TIMEOUT_EN
    check("timeout_count", n_timeout, 1);
    check("timeout_cycle", to_n, 4099);
    check("timeout_level", to_lvl, 1);
    check("timeout_state", to_state, ST_SYNC);
    check("static_level", m.static_level, 1);
`else
    check("timeout_count", n_timeout, 0);
    check("static_level", m.static_level, 0);
`endif

    // Reset while in HIGH
    repeat (3) run_pwm(3, 7);
    pwm_in = 1'b1;
    repeat (2) cycle();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_high_time", m.high_time, 0);
    check("mid_rst_period", m.period, 0);
    check("mid_rst_meas_valid", m.meas_valid, 0);
    check("mid_rst_meas_ovf", m.meas_ovf, 0);
    check("mid_rst_timeout", m.timeout, 0);
    check("mid_rst_static_level", m.static_level, 0);
    repeat (3) cycle();
    reset = 1'b0;
    reps.delete();
    repeat (2) cycle();
    pwm_in = 1'b0;
    repeat (7) cycle();
    repeat (3) run_pwm(3, 7);
    check("post_rst_reports", reps.size(), 2);
    for (int i = 0; i < reps.size(); i++) check_rep("post_rst", reps[i], 3, 10, 0);

    // 8-bit counters, 300 clk low time saturates the period
    reps8.delete();
    en8 = 1'b1;
    repeat (5) cycle();
    run_pwm8(2, 300);
    run_pwm8(2, 300);
    run_pwm8(3, 7);
    run_pwm8(3, 7);
    check("ovf_reports", reps8.size(), 3);
    if (reps8.size() > 0) check_rep("ovf_first", reps8[0], 2, 255, 1);
    if (reps8.size() > 1) check_rep("ovf_second", reps8[1], 2, 255, 1);
    if (reps8.size() > 2) check_rep("ovf_cleared", reps8[2], 3, 10, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
